// File: rtl/icache_fetch_responder_if.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder_if
//
// Bundles the core-to-icache fetch handshake and the single-beat refill memory
// port seen by the icache fetch responder.
//
// Signals (named from the responder's point of view):
//   i_flush      fetcher -> cache   invalidate all lines (fence.i)
//   i_req        fetcher -> cache   fetch request
//   i_get2       fetcher -> cache   request also needs the line at addr+1
//   i_addr       fetcher -> cache   block address of line0
//   o_gnt        cache -> fetcher   request accepted this cycle
//   o_rsp        cache -> fetcher   line data valid
//   o_line0      cache -> fetcher   line at granted addr
//   o_line1      cache -> fetcher   line at granted addr+1
//   o_mem_req    cache -> memory    refill read request
//   o_mem_addr   cache -> memory    refill block address
//   i_mem_gnt    memory -> cache    memory accepted request
//   i_mem_rvld   memory -> cache    refill data valid (one beat)
//   i_mem_rdata  memory -> cache    refill line
//
// Modports:
//   slave   the cache (icache_fetch_responder)
//   master  the environment: fetcher plus memory
// -----------------------------------------------------------------------------
interface icache_fetch_responder_if #(
    parameter int XLEN           = 64,
    parameter int CACHELINE_SIZE = 64,
    parameter int BLK_W          = XLEN - $clog2(CACHELINE_SIZE)
);
    localparam int LINE_W = CACHELINE_SIZE * 8;

    logic              i_flush;
    logic              i_req;
    logic              i_get2;
    logic [BLK_W-1:0]  i_addr;
    logic              o_gnt;
    logic              o_rsp;
    logic [LINE_W-1:0] o_line0;
    logic [LINE_W-1:0] o_line1;
    logic              o_mem_req;
    logic [BLK_W-1:0]  o_mem_addr;
    logic              i_mem_gnt;
    logic              i_mem_rvld;
    logic [LINE_W-1:0] i_mem_rdata;

    modport slave (
        input  i_flush, i_req, i_get2, i_addr,
        input  i_mem_gnt, i_mem_rvld, i_mem_rdata,
        output o_gnt, o_rsp, o_line0, o_line1,
        output o_mem_req, o_mem_addr
    );

    modport master (
        output i_flush, i_req, i_get2, i_addr,
        output i_mem_gnt, i_mem_rvld, i_mem_rdata,
        input  o_gnt, o_rsp, o_line0, o_line1,
        input  o_mem_req, o_mem_addr
    );
endinterface

// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Cache end of the core-to-icache fetch interface. Direct-mapped, with
// register-based tag/valid/data arrays. A request is granted combinationally
// when every line it needs is resident; line0 and line1 (addr, addr+1) are
// returned two cycles after the grant, fully pipelined. On a miss the grant is
// withheld and a refill FSM fetches one line at a time from a single-beat
// memory port. i_flush flash-invalidates all lines.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   icache_fetch_responder_if.slave (fetch handshake + refill port)
//
// Refill FSM:
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | hit check / grant; on a miss latch the missing block address
//   REQ    | o_mem_req raised with latched address, waiting for i_mem_gnt
//   WAIT   | waiting for the single refill beat (i_mem_rvld)
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
    parameter int XLEN           = 64,
    parameter int CACHELINE_SIZE = 64,
    parameter int SETS           = 64,
    parameter int BLK_W          = XLEN - $clog2(CACHELINE_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    icache_fetch_responder_if.slave     bus
);
    localparam int LINE_W = CACHELINE_SIZE * 8;
    localparam int IDX_W  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W  = BLK_W - IDX_W;

    // With a single set line0 and line1 share a slot and a get2 request can
    // never have both resident, so such a configuration would livelock.
    generate
        if (SETS < 2) begin : g_sets_check
            $error("icache_fetch_responder: SETS must be >= 2");
        end
        if ((1 << IDX_W) != SETS) begin : g_pow2_check
            $error("icache_fetch_responder: SETS must be a power of 2");
        end
        if ($bits(bus.i_addr) != BLK_W) begin : g_width_check
            $error("icache_fetch_responder: interface BLK_W mismatch");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Arrays
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // Address split
    logic [BLK_W-1:0] addr0, addr1;
    logic [IDX_W-1:0] idx0, idx1;
    logic [TAG_W-1:0] tag0, tag1;
    logic             hit0, hit1, hit;

    // Refill bookkeeping
    logic [BLK_W-1:0] miss_addr_q;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             flush_pend_q;

    // FSM outputs
    logic gnt;
    logic mem_req;
    logic miss_load;
    logic fill_we;

    // Response pipeline
    logic             s1_vld_q;
    logic [IDX_W-1:0] s1_idx0_q, s1_idx1_q;

    assign addr0 = bus.i_addr;
    assign addr1 = addr0 + BLK_W'(1);   // wraps modulo 2^BLK_W
    assign idx0  = addr0[IDX_W-1:0];
    assign idx1  = addr1[IDX_W-1:0];
    assign tag0  = addr0[BLK_W-1:IDX_W];
    assign tag1  = addr1[BLK_W-1:IDX_W];

    assign hit0 = valid_q[idx0] && (tag_q[idx0] == tag0);
    assign hit1 = valid_q[idx1] && (tag_q[idx1] == tag1);
    assign hit  = hit0 && (hit1 || !bus.i_get2);

    assign fill_idx = miss_addr_q[IDX_W-1:0];
    assign fill_tag = miss_addr_q[BLK_W-1:IDX_W];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req && !hit && !bus.i_flush) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.i_mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_mem_rvld) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // Everything is gated by rst so that a reset cycle neither grants nor
    // writes the arrays (a refill interrupted by reset is abandoned).
    // -------------------------------------------------------------------------
    always_comb begin
        gnt       = 1'b0;
        mem_req   = 1'b0;
        miss_load = 1'b0;
        fill_we   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    gnt       = bus.i_req && hit && !bus.i_flush;
                    miss_load = bus.i_req && !hit && !bus.i_flush;
                end
                S_REQ: begin
                    mem_req = 1'b1;
                end
                S_WAIT: begin
                    fill_we = bus.i_mem_rvld;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_gnt      = gnt;
    assign bus.o_mem_req  = mem_req;
    assign bus.o_mem_addr = miss_addr_q;

    // -------------------------------------------------------------------------
    // Miss address: line0 is refilled first; once it is present IDLE
    // re-evaluates and the same path picks up line1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr_q <= '0;
        end else if (miss_load) begin
            miss_addr_q <= hit0 ? addr1 : addr0;
        end
    end

    // A flush seen while a refill is outstanding means the returning line
    // predates the fence; it is still written but must not become valid.
    always_ff @(posedge clk) begin
        if (rst || (state_d == S_IDLE)) begin
            flush_pend_q <= 1'b0;
        end else if (bus.i_flush) begin
            flush_pend_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Arrays
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.i_flush) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[fill_idx] <= !flush_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.i_mem_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Response pipeline: grant at T, array read at T+1, o_rsp at T+2.
    // Flush/miss/refill never cancel an in-flight response; the data array
    // is only written in WAIT, which cannot overlap the T+1 read of a grant.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (gnt) begin
            s1_idx0_q <= idx0;
            s1_idx1_q <= idx1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            bus.o_rsp   <= 1'b0;
            bus.o_line0 <= '0;
            bus.o_line1 <= '0;
        end else begin
            s1_vld_q  <= gnt;
            bus.o_rsp <= s1_vld_q;
            if (s1_vld_q) begin
                bus.o_line0 <= data_q[s1_idx0_q];
                bus.o_line1 <= data_q[s1_idx1_q];
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch_responder
//
// Directed stimulus for icache_fetch_responder. Each grant pushes its expected
// response (line data plus grant cycle) onto rsp_q; a monitor pops and checks
// whenever o_rsp is seen. Expected refill addresses go onto mem_q; the memory
// model pops and checks them as it serves each o_mem_req.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;
    localparam int XLEN   = 64;
    localparam int CLS    = 64;
    localparam int SETS   = 64;
    localparam int BLK_W  = XLEN - $clog2(CLS);
    localparam int LINE_W = CLS * 8;

    typedef struct {
        logic [BLK_W-1:0]  a;
        logic [LINE_W-1:0] l0;
        logic [LINE_W-1:0] l1;
        bit                chk1;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t             rsp_q[$];
    logic [BLK_W-1:0] mem_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    bit               mem_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_fetch_responder_if #(.XLEN(XLEN), .CACHELINE_SIZE(CLS)) bus ();

    icache_fetch_responder #(
        .XLEN(XLEN), .CACHELINE_SIZE(CLS), .SETS(SETS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Distinct line content per block address, different in every word.
    function automatic logic [LINE_W-1:0] pat(input logic [BLK_W-1:0] a);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 64; w++) begin
            l[w*64 +: 64] = {6'd0, a} ^ 64'hC0DE_5EED_0000_0000 ^ (64'(w) << 56);
        end
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_rsp(input logic [BLK_W-1:0] a, input bit g2);
        exp_t e;
        e.a    = a;
        e.l0   = pat(a);
        e.l1   = pat(a + BLK_W'(1));
        e.chk1 = g2;
        e.cyc  = cyc;
        rsp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after a posedge, i_req low.
    task automatic fetch(input logic [BLK_W-1:0] a, input bit g2);
        int  k;
        bit  got;
        k   = 0;
        got = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        bus.i_get2 = g2;
        while (!got && k < 400) begin
            @(negedge clk);
            if (bus.o_gnt) begin
                got = 1'b1;
                push_rsp(a, g2);
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL fetch_gnt_timeout: addr %h got no grant expected grant", a);
        end
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
    endtask

    // Returns at a negedge where o_mem_req == lvl.
    task automatic wait_mem_req(input bit lvl);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.o_mem_req !== lvl && k < 200);
        n_vec++;
        if (bus.o_mem_req !== lvl) begin
            n_err++;
            $display("FAIL wait_mem_req: o_mem_req %b expected %b", bus.o_mem_req, lvl);
        end
    endtask

    // Response monitor
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_rsp === 1'b1) begin
                n_vec++;
                if (rsp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: line0[63:0] %h expected no response",
                             bus.o_line0[63:0]);
                end else begin
                    e = rsp_q.pop_front();
                    if (bus.o_line0 !== e.l0 || (e.chk1 && bus.o_line1 !== e.l1) ||
                        cyc != e.cyc + 2) begin
                        n_err++;
                        $display("FAIL rsp_%h: line0[63:0] %h line1[63:0] %h cyc %0d expected %h %h cyc %0d",
                                 e.a, bus.o_line0[63:0], bus.o_line1[63:0], cyc,
                                 e.l0[63:0], e.l1[63:0], e.cyc + 2);
                    end
                end
            end else if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc + 2) begin
                e = rsp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL rsp_missing_%h: o_rsp 0 expected 1 at cyc %0d", e.a, e.cyc + 2);
            end
        end
    end

    // Single-beat memory model
    initial begin : mem
        logic [BLK_W-1:0] a;
        int k;
        bus.i_mem_gnt   = 1'b0;
        bus.i_mem_rvld  = 1'b0;
        bus.i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req === 1'b1 && !rst) begin
                a = bus.o_mem_addr;
                n_vec++;
                if (mem_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_req_unexpected: addr %h expected no refill", a);
                end else if (a !== mem_q[0]) begin
                    n_err++;
                    $display("FAIL mem_addr: got %h expected %h", a, mem_q[0]);
                    void'(mem_q.pop_front());
                end else begin
                    void'(mem_q.pop_front());
                end
                @(posedge clk);
                #1 bus.i_mem_gnt = 1'b1;
                @(posedge clk);
                #1 bus.i_mem_gnt = 1'b0;
                repeat (2) @(posedge clk);
                k = 0;
                while (mem_stall && k < 200) begin
                    @(posedge clk);
                    k++;
                end
                #1;
                bus.i_mem_rvld  = 1'b1;
                bus.i_mem_rdata = pat(a);
                @(posedge clk);
                #1 bus.i_mem_rvld = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin : stim
        logic [BLK_W-1:0] sa [3];
        bit               sg [3];

        bus.i_flush = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_get2  = 1'b0;
        bus.i_addr  = '0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt",     64'(bus.o_gnt), 64'd0);
        chk("rst_rsp",     64'(bus.o_rsp), 64'd0);
        chk("rst_mem_req", 64'(bus.o_mem_req), 64'd0);
        chk("rst_line0",   64'(|bus.o_line0), 64'd0);
        chk("rst_line1",   64'(|bus.o_line1), 64'd0);
        @(posedge clk);
        #1;

        // Cold miss
        mem_q.push_back(58'h40);
        fetch(58'h40, 1'b0);

        // Double miss across the idx 63 -> idx 0 wrap; 0x80 evicts 0x40
        mem_q.push_back(58'h7F);
        mem_q.push_back(58'h80);
        fetch(58'h7F, 1'b1);

        // Conflict: 0x40 and 0x80 share idx 0
        mem_q.push_back(58'h40);
        fetch(58'h40, 1'b0);
        mem_q.push_back(58'h80);
        fetch(58'h80, 1'b0);
        mem_q.push_back(58'h40);
        fetch(58'h40, 1'b0);

        // Preload, then stream hits on consecutive cycles
        mem_q.push_back(58'h41);
        fetch(58'h41, 1'b0);
        mem_q.push_back(58'h42);
        fetch(58'h42, 1'b0);
        sa[0] = 58'h40; sg[0] = 1'b1;
        sa[1] = 58'h41; sg[1] = 1'b1;
        sa[2] = 58'h42; sg[2] = 1'b0;
        bus.i_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_addr = sa[i];
            bus.i_get2 = sg[i];
            @(negedge clk);
            n_vec++;
            if (bus.o_gnt !== 1'b1) begin
                n_err++;
                $display("FAIL stream_gnt_%0d: o_gnt %b expected 1", i, bus.o_gnt);
            end else begin
                push_rsp(sa[i], sg[i]);
            end
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0;

        // Flush: in-flight response survives, same-cycle grant suppressed
        fetch(58'h40, 1'b0);
        bus.i_req   = 1'b1;
        bus.i_addr  = 58'h40;
        bus.i_get2  = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        chk("flush_same_cycle_gnt", 64'(bus.o_gnt), 64'd0);
        chk("flush_no_mem_req",     64'(bus.o_mem_req), 64'd0);
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_req   = 1'b0;
        mem_q.push_back(58'h40);
        fetch(58'h40, 1'b0);

        // Flush during WAIT: refilled line stays invalid and is fetched again
        mem_stall = 1'b1;
        mem_q.push_back(58'h300);
        mem_q.push_back(58'h300);
        bus.i_req  = 1'b1;
        bus.i_addr = 58'h300;
        bus.i_get2 = 1'b0;
        wait_mem_req(1'b1);
        wait_mem_req(1'b0);
        @(posedge clk);
        #1 bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        mem_stall   = 1'b0;
        fetch(58'h300, 1'b0);

        // Reset during WAIT: late beat ignored, line not valid
        mem_stall = 1'b1;
        mem_q.push_back(58'h500);
        mem_q.push_back(58'h500);
        bus.i_req  = 1'b1;
        bus.i_addr = 58'h500;
        wait_mem_req(1'b1);
        wait_mem_req(1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_mem_req", 64'(bus.o_mem_req), 64'd0);
        chk("rst_wait_rsp",     64'(bus.o_rsp), 64'd0);
        @(posedge clk);
        #1;
        bus.i_req  = 1'b1;
        bus.i_addr = 58'h500;
        @(negedge clk);
        chk("rst_wait_line_invalid_gnt", 64'(bus.o_gnt), 64'd0);
        @(posedge clk);
        #1;
        fetch(58'h500, 1'b0);

        // Reset cleared 0x40 as well
        mem_q.push_back(58'h40);
        fetch(58'h40, 1'b0);

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Responder (cache) end of the core2icache fetch interface.
- The fetcher issues block-aligned fetch requests. This block grants them on a hit and returns two consecutive cachelines (line0, line1) exactly two cycles after the grant.
- On a miss it withholds the grant and runs a refill FSM against a single-beat memory port.
- Direct-mapped, register-based tag/valid arrays, flash-invalidate on flush (fence.i).

Parameters:
- XLEN, 64, address width in bits.
- CACHELINE_SIZE, 64, line size in bytes. Power of 2.
- SETS, 64, number of direct-mapped sets. Power of 2.
- BLK_W, XLEN-$clog2(CACHELINE_SIZE), block-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i_flush  in  1  invalidate all lines (fence.i).
- i_req  in  1  fetch request (core2icache req).
- i_get2  in  1  request also needs line at addr+1.
- i_addr  in  BLK_W  block address of line0.
- o_gnt  out  1  request accepted this cycle.
- o_rsp  out  1  line data valid.
- o_line0  out  CACHELINE_SIZE*8  line at granted addr.
- o_line1  out  CACHELINE_SIZE*8  line at granted addr+1.
- o_mem_req  out  1  refill read request.
- o_mem_addr  out  BLK_W  refill block address.
- i_mem_gnt  in  1  memory accepted request.
- i_mem_rvld  in  1  refill data valid (one beat).
- i_mem_rdata  in  CACHELINE_SIZE*8  refill line.

Behaviour:
- Address split:
  - index = addr[$clog2(SETS)-1:0]; tag = addr[BLK_W-1:$clog2(SETS)].
  - addr1 = addr+1, wrapping modulo 2^BLK_W.
- Hit check (combinational on valid/tag registers):
  - hit0 = valid[idx0] && tag[idx0]==tag0.
  - hit1 = valid[idx1] && tag[idx1]==tag1.
  - hit = hit0 && (hit1 || !i_get2).
- Grant: o_gnt = i_req && state==IDLE && hit && !i_flush. Combinational; the requester may drop i_req at any time without penalty.
- Response pipeline:
  - Grant at cycle T. Data array is read at T+1. o_rsp=1 with o_line0/o_line1 at T+2.
  - Fully pipelined: back-to-back grants yield back-to-back rsp.
  - When i_get2=0, o_line1 content is don't-care but still driven from idx1.
  - o_rsp is not blocked by a later flush or miss: a grant, once given, always produces its rsp.
- Refill FSM:
  - IDLE: if i_req && !hit && !i_flush, latch miss addr = hit0 ? addr1 : addr0, then go to REQ.
  - REQ: o_mem_req=1, o_mem_addr=miss addr. On i_mem_gnt go to WAIT.
  - WAIT: on i_mem_rvld, write data[idx]=rdata, tag[idx]=tag, valid[idx]=1, then go to IDLE.
  - A request needing two lines refills line0 first. IDLE re-evaluates and refills line1; the request is granted after both are present.
  - Miss address is latched at FSM entry. A changed i_req/i_addr during refill does not abort the refill.
- Flush: i_flush clears all valid bits next cycle. If a refill is in WAIT, the arriving line is written but its valid bit stays 0 (a flush-pending bit is cleared on return to IDLE).
- Simultaneous idx0==idx1 (SETS==1 only): treat as a miss on line1 after line0 is filled. This is a livelock; SETS>=2 is required and checked by an elaboration assert.
- Reset values:
  - o_gnt=0, o_rsp=0, o_mem_req=0, state=IDLE, all valid=0.
  - o_line0/o_line1 = 0.
  - Reset mid-refill abandons it: a later i_mem_rvld in IDLE is ignored.

Test Plan:
- Cold miss: rst, then i_req addr=0x40, get2=0 -> o_mem_req with addr 0x40. After mem returns pattern A, gnt asserts; rsp two cycles later with o_line0=A.
- Double miss: i_req addr=0x7F, get2=1 (idx 63, then wrap to idx 0) -> two refills in order 0x7F, 0x80, then gnt. At T+2, line0=data(0x7F), line1=data(0x80).
- Streaming hits: addresses 0x40,0x41,0x42 on consecutive cycles, all resident -> gnt every cycle and rsp on 3 consecutive cycles, in order.
- Conflict: fill 0x40, then request 0x80 (same idx 0, tag 2) -> miss and refill. Subsequent 0x40 misses again.
- Flush: resident line, pulse i_flush -> same-cycle gnt=0. Next request misses. Flush during WAIT leaves the refilled line invalid.
- Reset during WAIT, then i_mem_rvld arrives -> no array write, valid stays 0, o_mem_req=0.
